// File: rtl/uart_crc_pkg.sv
// Shared definitions for the UART/CRC-8 receive path.
//   BYTE_W      : width of a received byte
//   CRC_LAT_DEF : default cycles from rx_ready_in to the CRC verdict
//   DEPTH_DEF   : default byte-buffer FIFO depth
//   rxbuf_state_t : byte-buffer FSM states
package uart_crc_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned CRC_LAT_DEF = 2;
  localparam int unsigned DEPTH_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CRC = 2'd1,
    DECIDE   = 2'd2
  } rxbuf_state_t;

endpackage

// File: rtl/uart_rx_byte_buffer_if.sv
// Byte-stream bundle between the receiver/CRC checker, the byte buffer
// and its consumer.
//   rx_data_in/rx_ready_in : received byte and its one-cycle strobe
//   crc_valid_in           : CRC verdict for the held byte
//   out_data/out_valid     : FIFO head (first-word-fall-through)
//   out_ready              : consumer accepts the head
// slave  : the byte buffer side
// master : the environment (receiver + consumer) side
interface uart_rx_byte_buffer_if;
  import uart_crc_pkg::*;

  logic [BYTE_W-1:0] rx_data_in;
  logic              rx_ready_in;
  logic              crc_valid_in;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  rx_data_in, rx_ready_in, crc_valid_in, out_ready,
    output out_data, out_valid
  );

  modport master (
    output rx_data_in, rx_ready_in, crc_valid_in, out_ready,
    input  out_data, out_valid
  );

endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with first-word-fall-through head.
//   clk, reset   : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : write push_data_i (ignored when full unless popping)
//   pop_i        : remove head (ignored when empty)
//   head_o       : current head, forced to 0 while empty
//   level_o      : occupancy 0..DEPTH
//   empty_o/full_o : occupancy flags
module uart_byte_fifo
  import uart_crc_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [BYTE_W-1:0]          push_data_i,
  input  logic                       pop_i,
  output logic [BYTE_W-1:0]          head_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/uart_rx_byte_buffer.sv
// Byte buffer behind the UART receiver and CRC-8 checker. Holds each byte
// until its CRC verdict arrives CRC_LAT cycles later, stores good bytes in a
// FIFO and counts CRC rejects and overrun/full drops.
//   clk, reset    : clock, synchronous active-high reset
//   bus (slave)   : rx byte/strobe, CRC verdict, FWFT output port
//   fifo_level    : FIFO occupancy
//   crc_err_count : saturating count of CRC-rejected bytes
//   drop_count    : saturating count of overrun and FIFO-full drops
//   clear_counts  : synchronous clear of both counters
module uart_rx_byte_buffer
  import uart_crc_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned CRC_LAT = CRC_LAT_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_rx_byte_buffer_if.slave   bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       crc_err_count,
  output logic [CNT_W-1:0]       drop_count,
  input  logic                   clear_counts
);

  // WAIT_CRC lasts CRC_LAT-1 cycles: load CRC_LAT-2 and leave on zero.
  localparam int unsigned WAIT_LOAD = (CRC_LAT >= 2) ? CRC_LAT - 2 : 0;
  localparam int unsigned WAIT_W    = (WAIT_LOAD > 1) ? $clog2(WAIT_LOAD + 1) : 1;

  rxbuf_state_t      state_q, state_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  crc_err_q, crc_err_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic push, pop, full, empty, crc_err_inc, drop_inc;

  assign pop = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    wait_d      = wait_q;
    push        = 1'b0;
    crc_err_inc = 1'b0;
    drop_inc    = 1'b0;
    unique case (state_q)
      IDLE: ;
      WAIT_CRC: begin
        if (bus.rx_ready_in)   drop_inc = 1'b1;
        else if (wait_q == '0) state_d  = DECIDE;
        else                   wait_d   = wait_q - 1'b1;
      end
      DECIDE: begin
        if (!bus.crc_valid_in)  crc_err_inc = 1'b1;
        else if (!full || pop)  push        = 1'b1;
        else                    drop_inc    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new byte is latched in every state; in WAIT_CRC it overwrites the
    // pending one (counted above), in DECIDE it follows the resolved one.
    if (bus.rx_ready_in) begin
      hold_d = bus.rx_data_in;
      wait_d = WAIT_W'(WAIT_LOAD);
      if (CRC_LAT > 1) state_d = WAIT_CRC;
      else             state_d = DECIDE;
    end
  end

  always_comb begin
    crc_err_d = crc_err_q;
    drop_d    = drop_q;
    if (clear_counts) begin
      crc_err_d = '0;
      drop_d    = '0;
    end else begin
      if (crc_err_inc && crc_err_q != '1) crc_err_d = crc_err_q + 1'b1;
      if (drop_inc && drop_q != '1)       drop_d    = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      wait_q    <= '0;
      crc_err_q <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      wait_q    <= wait_d;
      crc_err_q <= crc_err_d;
      drop_q    <= drop_d;
    end
  end

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (hold_q),
    .pop_i       (pop),
    .head_o      (bus.out_data),
    .level_o     (fifo_level),
    .empty_o     (empty),
    .full_o      (full)
  );

  assign bus.out_valid = !empty;
  assign crc_err_count = crc_err_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_uart_rx_byte_buffer.sv
// Bench for uart_rx_byte_buffer: instance A (DEPTH=16, CRC_LAT=2) and
// instance B (DEPTH=16, CRC_LAT=3). Expected bytes are queued at stimulus
// time; per-instance monitors pop and compare on every accepted output.
module tb_uart_rx_byte_buffer;
  import uart_crc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_byte_buffer_if ifa ();
  uart_rx_byte_buffer_if ifb ();

  logic [4:0]  lvl_a, lvl_b;
  logic [15:0] err_a, drop_a, err_b, drop_b;
  logic        clr_a, clr_b;

  uart_rx_byte_buffer #(.DEPTH(16), .CRC_LAT(2), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .bus(ifa), .fifo_level(lvl_a),
    .crc_err_count(err_a), .drop_count(drop_a), .clear_counts(clr_a)
  );

  uart_rx_byte_buffer #(.DEPTH(16), .CRC_LAT(3), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .bus(ifb), .fifo_level(lvl_b),
    .crc_err_count(err_b), .drop_count(drop_b), .clear_counts(clr_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] e_a, e_b;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard monitors: every accepted head must match the queued byte.
  always @(negedge clk) begin
    if (!reset && ifa.out_valid && ifa.out_ready) begin
      n_cmp++;
      if (q_a.size() == 0) begin
        n_bad++;
        $display("FAIL a_pop_unexpected: got %02h, expected no data", ifa.out_data);
      end else begin
        e_a = q_a.pop_front();
        if (ifa.out_data !== e_a) begin
          n_bad++;
          $display("FAIL a_pop_data: got %02h, expected %02h", ifa.out_data, e_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ifb.out_valid && ifb.out_ready) begin
      n_cmp++;
      if (q_b.size() == 0) begin
        n_bad++;
        $display("FAIL b_pop_unexpected: got %02h, expected no data", ifb.out_data);
      end else begin
        e_b = q_b.pop_front();
        if (ifb.out_data !== e_b) begin
          n_bad++;
          $display("FAIL b_pop_data: got %02h, expected %02h", ifb.out_data, e_b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // One-cycle rx strobe on A in the current cycle; verdict held afterwards.
  task automatic pulse_a(input logic [7:0] d, input logic good);
    ifa.rx_ready_in  = 1'b1;
    ifa.rx_data_in   = d;
    ifa.crc_valid_in = good;
    tick();
    ifa.rx_ready_in  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ifa.rx_data_in = '0; ifa.rx_ready_in = 1'b0; ifa.crc_valid_in = 1'b0; ifa.out_ready = 1'b0;
    ifb.rx_data_in = '0; ifb.rx_ready_in = 1'b0; ifb.crc_valid_in = 1'b0; ifb.out_ready = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    tick(); tick();
    at_neg();
    chk("rst_valid", ifa.out_valid, 0);
    chk("rst_data", ifa.out_data, 8'h00);
    chk("rst_level", lvl_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_drop", drop_a, 0);
    tick();
    reset = 1'b0;

    // Good byte: DECIDE at T+2, visible at T+3.
    q_a.push_back(8'hA5);
    pulse_a(8'hA5, 1'b1);
    tick();
    at_neg();
    chk("t1_valid_at_decide", ifa.out_valid, 0);
    tick();
    at_neg();
    chk("t1_valid", ifa.out_valid, 1);
    chk("t1_data", ifa.out_data, 8'hA5);
    chk("t1_level", lvl_a, 1);
    chk("t1_err", err_a, 0);
    chk("t1_drop", drop_a, 0);
    tick(); ifa.out_ready = 1'b1;
    tick(); ifa.out_ready = 1'b0;
    at_neg();
    chk("t1_level_after_pop", lvl_a, 0);

    // Bad byte: discarded, error counted the cycle after DECIDE.
    pulse_a(8'h3C, 1'b0);
    tick();
    at_neg();
    chk("t2_err_at_decide", err_a, 0);
    tick();
    at_neg();
    chk("t2_err", err_a, 1);
    chk("t2_valid", ifa.out_valid, 0);

    // 17 good bytes into a 16-deep FIFO: last one dropped.
    tick();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) q_a.push_back(8'h40 + 8'(i));
      pulse_a(8'h40 + 8'(i), 1'b1);
      tick(); tick();
    end
    at_neg();
    chk("t3_level_full", lvl_a, 16);
    chk("t3_drop", drop_a, 1);
    chk("t3_err", err_a, 1);
    chk("t3_head", ifa.out_data, 8'h40);
    tick(); ifa.out_ready = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    at_neg();
    chk("t3_valid_last", ifa.out_valid, 1);
    chk("t3_level_last", lvl_a, 1);
    tick();
    at_neg();
    chk("t3_valid_drained", ifa.out_valid, 0);
    chk("t3_level_drained", lvl_a, 0);
    ifa.out_ready = 1'b0;

    // Full FIFO, good byte decided in the same cycle as a pop.
    tick();
    for (int i = 0; i < 16; i++) begin
      q_a.push_back(8'h60 + 8'(i));
      pulse_a(8'h60 + 8'(i), 1'b1);
      tick(); tick();
    end
    q_a.push_back(8'h99);
    pulse_a(8'h99, 1'b1);
    tick(); ifa.out_ready = 1'b1;
    tick(); ifa.out_ready = 1'b0;
    at_neg();
    chk("t5_level", lvl_a, 16);
    chk("t5_drop", drop_a, 1);
    chk("t5_head", ifa.out_data, 8'h61);
    tick(); ifa.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) tick();
    at_neg();
    chk("t5_valid_drained", ifa.out_valid, 0);
    chk("t5_queue_empty", q_a.size(), 0);
    ifa.out_ready = 1'b0;

    // Reset while a byte waits for its verdict, with 5 entries stored.
    tick();
    for (int i = 0; i < 5; i++) begin
      q_a.push_back(8'h80 + 8'(i));
      pulse_a(8'h80 + 8'(i), 1'b1);
      tick(); tick();
    end
    pulse_a(8'hEE, 1'b1);
    reset = 1'b1;
    ifa.rx_ready_in = 1'b1;
    ifa.rx_data_in  = 8'h55;
    at_neg();
    chk("t6_level_pre", lvl_a, 5);
    q_a.delete();
    tick();
    reset = 1'b0;
    ifa.rx_ready_in = 1'b0;
    at_neg();
    chk("t6_valid", ifa.out_valid, 0);
    chk("t6_data", ifa.out_data, 8'h00);
    chk("t6_level", lvl_a, 0);
    chk("t6_err", err_a, 0);
    chk("t6_drop", drop_a, 0);
    ifa.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    at_neg();
    chk("t6_no_ghost", ifa.out_valid, 0);
    ifa.out_ready = 1'b0;

    // Instance B (CRC_LAT=3): overrun 0x11 -> 0x22.
    tick();
    q_b.push_back(8'h22);
    ifb.rx_ready_in = 1'b1; ifb.rx_data_in = 8'h11; ifb.crc_valid_in = 1'b1;
    tick();
    ifb.rx_data_in = 8'h22;
    tick();
    ifb.rx_ready_in = 1'b0;
    at_neg();
    chk("t4_drop", drop_b, 1);
    tick(); tick();
    at_neg();
    chk("t4_valid_at_decide", ifb.out_valid, 0);
    tick();
    at_neg();
    chk("t4_valid", ifb.out_valid, 1);
    chk("t4_data", ifb.out_data, 8'h22);
    chk("t4_level", lvl_b, 1);
    chk("t4_err", err_b, 0);
    tick(); ifb.out_ready = 1'b1;
    tick(); ifb.out_ready = 1'b0;
    at_neg();
    chk("t4_level_drained", lvl_b, 0);

    // Clear coincides with an overrun increment; clear wins.
    tick();
    ifb.rx_ready_in = 1'b1; ifb.rx_data_in = 8'h33; ifb.crc_valid_in = 1'b0;
    tick();
    ifb.rx_data_in = 8'h44; clr_b = 1'b1;
    tick();
    ifb.rx_ready_in = 1'b0; clr_b = 1'b0;
    at_neg();
    chk("t7_drop_cleared", drop_b, 0);
    tick(); tick(); tick();
    at_neg();
    chk("t7_err", err_b, 1);
    chk("t7_valid", ifb.out_valid, 0);
    chk("t7_queue_empty", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
